// File: rtl/uncache_mem_resp.sv
// Uncached memory responder: 64-bit backing RAM, stores commit on acceptance,
// loads return after a fixed latency through a valid/ready response handshake.
module uncache_mem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uncache_mem_vld_i,
   output logic        uncache_mem_ready_o,
   input  logic        uncache_mem_write_i,
   input  logic [2:0]  uncache_mem_size_i,
   input  logic [63:0] uncache_mem_addr_i,
   input  logic [63:0] uncache_mem_wdata_i,
   output logic        uncache_mem_resp_vld_o,
   input  logic        uncache_mem_resp_rdy_i,
   output logic [63:0] uncache_mem_resp_data_o,
   output logic        uncache_mem_err_o
);
   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   // Request handshake: a request transfers on a rising edge where vld && ready.
   // Response handshake: data transfers on a rising edge where resp_vld && resp_rdy;
   // resp_vld and resp_data stay stable until then.
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [63:0]       mem [DEPTH_WORDS];

   logic [63:0]       off, size_mask, wmask, wdata_sh, rd_word, rd_data;
   logic [IDX_W-1:0]  idx;
   logic [2:0]        lane, align_mask;
   logic [5:0]        lane_sh;
   logic              in_range, aligned, req_ok;
   logic              accept, ld_accept, st_accept;
   logic              unused_size_hi;

   assign unused_size_hi = uncache_mem_size_i[2];

   assign off      = uncache_mem_addr_i - BASE_ADDR;
   assign idx      = off[IDX_W+2:3];
   assign lane     = uncache_mem_addr_i[2:0];
   assign lane_sh  = {lane, 3'b000};
   assign in_range = (uncache_mem_addr_i >= BASE_ADDR) && (off < SPAN);

   always_comb begin
      size_mask  = 64'hFF;
      align_mask = 3'b000;
      case (uncache_mem_size_i[1:0])
         2'd0: begin size_mask = 64'h0000_0000_0000_00FF; align_mask = 3'b000; end
         2'd1: begin size_mask = 64'h0000_0000_0000_FFFF; align_mask = 3'b001; end
         2'd2: begin size_mask = 64'h0000_0000_FFFF_FFFF; align_mask = 3'b011; end
         default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; align_mask = 3'b111; end
      endcase
   end

   assign aligned   = (lane & align_mask) == 3'b000;
   assign req_ok    = in_range && aligned;
   assign accept    = uncache_mem_vld_i && (state == IDLE);
   assign ld_accept = accept && !uncache_mem_write_i;
   assign st_accept = accept && uncache_mem_write_i;

   // Aligned accesses never spill past byte 7, so plain shifts place the lanes.
   assign wmask    = size_mask << lane_sh;
   assign wdata_sh = uncache_mem_wdata_i << lane_sh;
   assign rd_word  = mem[idx];
   assign rd_data  = req_ok ? ((rd_word >> lane_sh) & size_mask) : 64'h0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (ld_accept) begin
               if (LATENCY <= 1) begin
                  state_nxt = RESP;
                  cnt_nxt   = 4'd0;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            if (uncache_mem_resp_rdy_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= IDLE;
         cnt                     <= 4'd0;
         uncache_mem_resp_data_o <= 64'h0;
         uncache_mem_err_o       <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (ld_accept) uncache_mem_resp_data_o <= rd_data;
         if (accept && !req_ok) uncache_mem_err_o <= 1'b1;
      end
   end

   // RAM has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (!rst && st_accept && req_ok)
         mem[idx] <= (mem[idx] & ~wmask) | (wdata_sh & wmask);
   end

   assign uncache_mem_ready_o    = (state == IDLE);
   assign uncache_mem_resp_vld_o = (state == RESP);
endmodule

// File: tb/tb_uncache_mem_resp.sv
// Directed bench for uncache_mem_resp: store/load merge, latency, backpressure,
// error flag and reset behaviour with hand-computed expectations.
module tb_uncache_mem_resp;
   localparam int unsigned DEPTH_WORDS = 1024;
   localparam int unsigned LATENCY     = 2;
   localparam logic [63:0] BASE        = 64'h8000_0000;
   localparam logic [63:0] SPAN        = 64'(DEPTH_WORDS) * 64'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld, ready, write, resp_vld, resp_rdy, err;
   logic [2:0]  size;
   logic [63:0] addr, wdata, resp_data;

   int checks = 0;
   int errors = 0;

   uncache_mem_resp #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .uncache_mem_vld_i       (vld),
      .uncache_mem_ready_o     (ready),
      .uncache_mem_write_i     (write),
      .uncache_mem_size_i      (size),
      .uncache_mem_addr_i      (addr),
      .uncache_mem_wdata_i     (wdata),
      .uncache_mem_resp_vld_o  (resp_vld),
      .uncache_mem_resp_rdy_i  (resp_rdy),
      .uncache_mem_resp_data_o (resp_data),
      .uncache_mem_err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d);
      vld = 1'b1; write = 1'b1; size = sz; addr = a; wdata = d;
      tick();
      vld = 1'b0; write = 1'b0;
   endtask

   // Issues a load, waits a bounded time for resp_vld, checks latency and data,
   // and completes the handshake when resp_rdy is high.
   task automatic load(input string tag, input logic [2:0] sz, input logic [63:0] a,
                       input logic [63:0] exp);
      int n;
      vld = 1'b1; write = 1'b0; size = sz; addr = a;
      tick();
      vld = 1'b0;
      n = 0;
      while (!resp_vld && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(LATENCY - 1));
      check({tag, "_data"}, resp_data, exp);
      check({tag, "_ready_low"}, {63'h0, ready}, 64'h0);
      if (resp_rdy) begin
         tick();
         check({tag, "_vld_drop"}, {63'h0, resp_vld}, 64'h0);
         check({tag, "_ready_back"}, {63'h0, ready}, 64'h1);
      end
   endtask

   initial begin
      rst = 1'b1; vld = 1'b0; write = 1'b0; size = 3'd0; addr = 64'h0; wdata = 64'h0;
      resp_rdy = 1'b1;
      tick(); tick();
      check("rst_ready", {63'h0, ready}, 64'h1);
      check("rst_resp_vld", {63'h0, resp_vld}, 64'h0);
      check("rst_resp_data", resp_data, 64'h0);
      check("rst_err", {63'h0, err}, 64'h0);
      rst = 1'b0;

      // Full doubleword round trip
      store(3'd3, BASE, 64'h1122_3344_5566_7788);
      load("ld_d", 3'd3, BASE, 64'h1122_3344_5566_7788);
      check("ld_d_err", {63'h0, err}, 64'h0);

      // Sub-word merge
      store(3'd0, BASE + 64'd3, 64'hFFFF_FFFF_FFFF_FFAA);
      load("ld_w", 3'd2, BASE, 64'h0000_0000_AA66_7788);
      load("ld_h", 3'd1, BASE + 64'd2, 64'h0000_0000_0000_AA66);
      load("ld_b", 3'd0, BASE + 64'd3, 64'h0000_0000_0000_00AA);

      // Backpressure on the response
      resp_rdy = 1'b0;
      load("bp", 3'd3, BASE, 64'h1122_3344_AA66_7788);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_vld_hold", {63'h0, resp_vld}, 64'h1);
         check("bp_data_hold", resp_data, 64'h1122_3344_AA66_7788);
         check("bp_ready_low", {63'h0, ready}, 64'h0);
      end
      resp_rdy = 1'b1;
      tick();
      check("bp_vld_drop", {63'h0, resp_vld}, 64'h0);
      check("bp_ready_back", {63'h0, ready}, 64'h1);

      // Misaligned load returns zero and raises err
      load("misal", 3'd2, BASE + 64'd2, 64'h0);
      check("misal_err", {63'h0, err}, 64'h1);

      // Reset clears err; out-of-range store is dropped and flagged
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("err_cleared", {63'h0, err}, 64'h0);
      store(3'd3, BASE + SPAN - 64'd8, 64'hCAFE_F00D_1234_5678);
      check("top_store_err", {63'h0, err}, 64'h0);
      store(3'd3, BASE + SPAN, 64'hDEAD_BEEF_DEAD_BEEF);
      check("oor_err", {63'h0, err}, 64'h1);
      load("top_word", 3'd3, BASE + SPAN - 64'd8, 64'hCAFE_F00D_1234_5678);

      // Back-to-back stores, one per cycle
      vld = 1'b1; write = 1'b1; size = 3'd3;
      for (int i = 0; i < 4; i++) begin
         addr  = BASE + 64'h10 + 64'(i * 8);
         wdata = 64'hA5A5_0000_0000_0000 + 64'(i);
         check("b2b_ready", {63'h0, ready}, 64'h1);
         tick();
      end
      vld = 1'b0; write = 1'b0;
      load("b2b_0", 3'd3, BASE + 64'h10, 64'hA5A5_0000_0000_0000);
      load("b2b_1", 3'd3, BASE + 64'h18, 64'hA5A5_0000_0000_0001);
      load("b2b_2", 3'd3, BASE + 64'h20, 64'hA5A5_0000_0000_0002);
      load("b2b_3", 3'd3, BASE + 64'h28, 64'hA5A5_0000_0000_0003);

      // Reset while a load is in BUSY
      vld = 1'b1; write = 1'b0; size = 3'd3; addr = BASE + 64'h10;
      tick();
      vld = 1'b0;
      check("mid_busy", {63'h0, ready}, 64'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_ready", {63'h0, ready}, 64'h1);
      for (int i = 0; i < 6; i++) begin
         check("mid_no_resp", {63'h0, resp_vld}, 64'h0);
         tick();
      end
      load("mid_keep", 3'd3, BASE + 64'h10, 64'hA5A5_0000_0000_0000);
      load("mid_keep2", 3'd3, BASE + SPAN - 64'd8, 64'hCAFE_F00D_1234_5678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uncache_mem_resp.md
# uncache_mem_resp

Responder end of the uncached memory interface driven by the LSU. It accepts one request at a time. It contains a synchronous 64-bit-wide backing RAM and performs stores immediately on acceptance. It returns load data after a fixed, programmable latency using a valid/ready response handshake. It serves as the uncached memory/MMIO model behind the core in simulation and small FPGA builds.

## Interface
- DEPTH_WORDS, 1024 — number of 64-bit RAM words (power of two).
- LATENCY, 2 — cycles from load acceptance edge to first cycle of `uncache_mem_resp_vld_o`; legal range 1..15.
- BASE_ADDR, 64'h8000_0000 — byte address of RAM word 0; must be 8-byte aligned.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- uncache_mem_vld_i  in  1  request valid.
- uncache_mem_ready_o  out  1  request ready.
- uncache_mem_write_i  in  1  1 = store, 0 = load.
- uncache_mem_size_i  in  3  log2 bytes in [1:0] (0=B, 1=H, 2=W, 3=D); bit 2 ignored.
- uncache_mem_addr_i  in  64  byte address.
- uncache_mem_wdata_i  in  64  store data, right-aligned (bits above size ignored).
- uncache_mem_resp_vld_o  out  1  load response valid.
- uncache_mem_resp_rdy_i  in  1  load response ready.
- uncache_mem_resp_data_o  out  64  load data, right-aligned, zero-extended.
- uncache_mem_err_o  out  1  sticky error flag; set on a misaligned or out-of-range request.

## Operation
- A request is accepted on a rising edge where `vld_i && ready_o`.
- States are IDLE, BUSY and RESP. `ready_o = (state==IDLE)`.
- Index calculation: `off = addr - BASE_ADDR`, `idx = off[63:3]`, `lane = addr[2:0]`.
  - In range means `addr >= BASE_ADDR` and `off < DEPTH_WORDS*8`.
  - Aligned means `addr` mod (1<<size) == 0.
- Store accepted in IDLE:
  - If in range and aligned, write bytes `lane .. lane+(1<<size)-1` of word `idx` with the low (1<<size) bytes of wdata. Other bytes are untouched.
  - Otherwise, drop the write and set err.
  - No response is generated. State stays IDLE, so back-to-back stores are accepted one per cycle.
- Load accepted in IDLE:
  - Snapshot the read result at the acceptance edge. The result is bytes `lane..` of word `idx`, shifted to bit 0, with upper bits zeroed.
  - If out of range or misaligned, the result is 64'h0 and err is set.
  - Load counter with LATENCY-1 and go to BUSY. If LATENCY==1, go directly to RESP.
- BUSY: decrement the counter each cycle. When it reaches 0, go to RESP.
- RESP: `resp_vld_o=1`. `resp_data_o` is held stable until `resp_rdy_i`. On handshake, go to IDLE.
- A store accepted in the same cycle as an earlier store to the same word is not possible (one per edge). A load sees all stores accepted on earlier edges.
- `err_o` is cleared only by reset.
- Reset mid-operation: a pending load is discarded and no response is issued. RAM contents are not reset and are preserved across reset.

## Timing
- Reset values: `ready_o=1` (IDLE), `resp_vld_o=0`, `resp_data_o=0`, `err_o=0`, counter=0.
- Load latency: accept at edge T gives `resp_vld_o` high in the cycle after edge T+LATENCY-1 (LATENCY=1 means high in the cycle right after acceptance).
- `ready_o` is low from the cycle after load acceptance through the response handshake cycle, and high again in the cycle after the handshake.
- Minimum load-to-load spacing is LATENCY+1 cycles with `resp_rdy_i` tied high.
- Store throughput is 1 per cycle. A store write is visible to a load accepted on the next edge.
- `resp_vld_o` must not drop and `resp_data_o` must not change while `resp_rdy_i` is low.
- `err_o` rises in the cycle after the offending acceptance.

## Test plan
- Store D 64'h1122334455667788 to BASE_ADDR, then load D from BASE_ADDR (LATENCY=2, rdy=1).
  - Required: resp_vld high 2 cycles after accept, data 64'h1122334455667788, err 0.
- Byte/half/word merge:
  - Store B 8'hAA to BASE+3.
  - Load W from BASE+0 → 64'h00000000_AA667788.
  - Load H from BASE+2 → 64'h0000_0000_0000_AA66.
  - Load B from BASE+3 → 64'hAA.
- Backpressure: hold resp_rdy=0 for 5 cycles after resp_vld rises.
  - Required: vld and data stable, ready_o low throughout. Handshake on release; ready_o high in the next cycle.
- Errors:
  - Load W from BASE+2 (misaligned) → data 0, err_o=1.
  - After reset, store D to BASE+DEPTH_WORDS*8 → err_o=1, and a load from BASE+DEPTH_WORDS*8-8 is unchanged.
- Back-to-back stores on 4 consecutive cycles to BASE+0x10..0x28 (D): ready_o stays 1, all four read back correctly.
- Reset mid-load: assert rst while in BUSY.
  - Required: no resp_vld ever appears, ready_o=1 the cycle after reset. Previously stored data still reads back.
